// File: rtl/mem_io_bridge.sv
// Memory-side access bridge: one BRAM or memory-mapped I/O transaction per mem_mem_ena window.
// Optional per-direction access counters are enabled with `define MEM_ACCESS_CNT_EN.
module mem_io_bridge #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_mem_ena,
    input  logic              mem_wr_ena,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    input  logic [15:0]       sw_i,
    output logic [15:0]       hex_o,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [15:0]       bram_din,
    input  logic [15:0]       bram_dout
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
`endif
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, DONE} state_e;

    state_e              state_q, state_d;
    logic                sel_io_q, sel_io_d;
    logic                sel_oor_q, sel_oor_d;
    logic                sel_wr_q, sel_wr_d;
    logic [DATA_W-1:0]   io_q, io_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   hex_q, hex_d;
    logic [DATA_W-1:0]   sw_meta_q, sw_sync_q;

    logic                start_c;
    logic                dec_io_c;
    logic                dec_oor_c;
    logic                rd_window_c;
    logic [DATA_W-1:0]   wait2_rdata_c;

`ifdef MEM_ACCESS_CNT_EN
    logic [DATA_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0]   wr_cnt_q, wr_cnt_d;
`endif

    // Next-state, window decode and capture logic
    always_comb begin
        state_d       = state_q;
        sel_io_d      = sel_io_q;
        sel_oor_d     = sel_oor_q;
        sel_wr_d      = sel_wr_q;
        io_d          = io_q;
        rdata_d       = rdata_q;
        hex_d         = hex_q;
        start_c       = (state_q == IDLE) && mem_mem_ena;
        dec_io_c      = (mem_addr == IO_ADDR);
        dec_oor_c     = !dec_io_c && ((mem_addr >> ADDR_W) != '0);
        rd_window_c   = (state_q == WAIT2) && !sel_wr_q;
        wait2_rdata_c = sel_oor_q ? '0 : (sel_io_q ? io_q : bram_dout);
`ifdef MEM_ACCESS_CNT_EN
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
`endif

        // Any state drops back to IDLE when the window closes
        case (state_q)
            IDLE:    state_d = mem_mem_ena ? WAIT1 : IDLE;
            WAIT1:   state_d = mem_mem_ena ? WAIT2 : IDLE;
            WAIT2:   state_d = mem_mem_ena ? DONE  : IDLE;
            DONE:    state_d = mem_mem_ena ? DONE  : IDLE;
            default: state_d = IDLE;
        endcase

        if (start_c) begin
            sel_io_d  = dec_io_c;
            sel_oor_d = dec_oor_c;
            sel_wr_d  = mem_wr_ena;
            io_d      = sw_sync_q;
            if (dec_io_c && mem_wr_ena) begin
                hex_d = mem_wdata;
            end
`ifdef MEM_ACCESS_CNT_EN
            if (mem_wr_ena) begin
                wr_cnt_d = wr_cnt_q + DATA_W'(1);
            end else begin
                rd_cnt_d = rd_cnt_q + DATA_W'(1);
            end
`endif
        end

        // Only a completed read window updates the held read data
        if (rd_window_c && mem_mem_ena) begin
            rdata_d = wait2_rdata_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_io_q  <= 1'b0;
            sel_oor_q <= 1'b0;
            sel_wr_q  <= 1'b0;
            io_q      <= '0;
            rdata_q   <= '0;
            hex_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
`ifdef MEM_ACCESS_CNT_EN
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_io_q  <= sel_io_d;
            sel_oor_q <= sel_oor_d;
            sel_wr_q  <= sel_wr_d;
            io_q      <= io_d;
            rdata_q   <= rdata_d;
            hex_q     <= hex_d;
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
`ifdef MEM_ACCESS_CNT_EN
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
`endif
        end
    end

    // BRAM strobes are single-cycle at t0 so the registered BRAM output lands in WAIT2
    assign bram_ena  = reset_n && start_c && !dec_io_c && !dec_oor_c;
    assign bram_wea  = bram_ena && mem_wr_ena;
    assign bram_addr = mem_addr[ADDR_W-1:0];
    assign bram_din  = mem_wdata;
    assign mem_rdata = rd_window_c ? wait2_rdata_c : rdata_q;
    assign hex_o     = hex_q;

`ifdef MEM_ACCESS_CNT_EN
    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed, table-driven bench for mem_io_bridge with a 2-cycle registered BRAM model.
module tb_mem_io_bridge;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              reset_n;
    logic              mem_mem_ena;
    logic              mem_wr_ena;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic [15:0]       sw_i;
    logic [15:0]       hex_o;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addr;
    logic [15:0]       bram_din;
    logic [15:0]       bram_dout;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0]       rd_cnt_o;
    logic [15:0]       wr_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    mem_io_bridge #(.ADDR_W(ADDR_W), .IO_ADDR(16'hFFFF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_mem_ena (mem_mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .sw_i        (sw_i),
        .hex_o       (hex_o),
        .bram_ena    (bram_ena),
        .bram_wea    (bram_wea),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_dout   (bram_dout)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_cnt_o    (rd_cnt_o),
        .wr_cnt_o    (wr_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: read-first array, internal read stage plus output register
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] rd_stage;
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
        mem[16] = 16'h1234;
        rd_stage  = 16'h0000;
        bram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) mem[bram_addr] <= bram_din;
            rd_stage <= mem[bram_addr];
        end
        bram_dout <= rd_stage;
    end

    typedef struct {
        logic        rst_n;
        logic        ena;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_rdata;
        logic [15:0] exp_hex;
        logic        exp_be;
        logic        exp_we;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic w, logic [15:0] a, logic [15:0] d,
                                logic [15:0] s, logic [15:0] er, logic [15:0] eh,
                                logic ebe, logic ewe);
        vec_t v;
        v.rst_n = r; v.ena = e; v.wr = w; v.addr = a; v.wdata = d; v.sw = s;
        v.exp_rdata = er; v.exp_hex = eh; v.exp_be = ebe; v.exp_we = ewe;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check outputs before the rising edge
    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        reset_n     = v.rst_n;
        mem_mem_ena = v.ena;
        mem_wr_ena  = v.wr;
        mem_addr    = v.addr;
        mem_wdata   = v.wdata;
        sw_i        = v.sw;
        #1;
        chk("mem_rdata", row, mem_rdata, v.exp_rdata);
        chk("hex_o", row, hex_o, v.exp_hex);
        chk("bram_ena", row, 16'(bram_ena), 16'(v.exp_be));
        chk("bram_wea", row, 16'(bram_wea), 16'(v.exp_we));
        if (v.exp_be) chk("bram_addr", row, 16'(bram_addr), 16'(v.addr[ADDR_W-1:0]));
        if (v.exp_we) chk("bram_din", row, bram_din, v.wdata);
    endtask

    initial begin
        reset_n     = 1'b0;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b0;
        mem_addr    = 16'h0010;
        mem_wdata   = 16'h0000;
        sw_i        = 16'h0000;
        repeat (2) @(posedge clk);

        // reset with an active window
        vecs.push_back(mk(0,1,0,16'h0010,16'h0000,16'h0000,16'h0000,16'h0000,0,0)); // 0
        vecs.push_back(mk(1,0,0,16'h0010,16'h0000,16'h0000,16'h0000,16'h0000,0,0));
        // BRAM read of 0x0010
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h0000,16'h0000,16'h0000,1,0)); // 2
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h0000,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h0000,16'h1234,16'h0000,0,0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h0000,16'h1234,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0010,16'h0000,16'h0000,16'h1234,16'h0000,0,0));
        // BRAM write 0x00A5 -> 0x0020, then read it back
        vecs.push_back(mk(1,1,1,16'h0020,16'h00A5,16'h0000,16'h1234,16'h0000,1,1)); // 7
        vecs.push_back(mk(1,1,1,16'h0020,16'h00A5,16'h0000,16'h1234,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,16'h0020,16'h00A5,16'h0000,16'h1234,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h0000,16'h1234,16'h0000,0,0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h0000,16'h1234,16'h0000,1,0)); // 11
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h0000,16'h1234,16'h0000,0,0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h0000,16'h00A5,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h0000,16'h00A5,16'h0000,0,0)); // 14
        // I/O write to hex, then switch read
        vecs.push_back(mk(1,1,1,16'hFFFF,16'hBEEF,16'h5A5A,16'h00A5,16'h0000,0,0)); // 15
        vecs.push_back(mk(1,1,1,16'hFFFF,16'hBEEF,16'h5A5A,16'h00A5,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,1,16'hFFFF,16'hBEEF,16'h5A5A,16'h00A5,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'hFFFF,16'h0000,16'h5A5A,16'h00A5,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'hFFFF,16'h0000,16'h5A5A,16'h00A5,16'hBEEF,0,0)); // 19
        vecs.push_back(mk(1,1,0,16'hFFFF,16'h0000,16'h5A5A,16'h00A5,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'hFFFF,16'h0000,16'h5A5A,16'h5A5A,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'hFFFF,16'h0000,16'h5A5A,16'h5A5A,16'hBEEF,0,0));
        // out-of-range read and write
        vecs.push_back(mk(1,1,0,16'h0400,16'h0000,16'h5A5A,16'h5A5A,16'hBEEF,0,0)); // 23
        vecs.push_back(mk(1,1,0,16'h0400,16'h0000,16'h5A5A,16'h5A5A,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'h0400,16'h0000,16'h5A5A,16'h0000,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'h0400,16'h0000,16'h5A5A,16'h0000,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,1,16'h0400,16'h1111,16'h5A5A,16'h0000,16'hBEEF,0,0)); // 27
        vecs.push_back(mk(1,1,1,16'h0400,16'h1111,16'h5A5A,16'h0000,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,1,16'h0400,16'h1111,16'h5A5A,16'h0000,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'h0400,16'h0000,16'h5A5A,16'h0000,16'hBEEF,0,0));
        // read 0x0010 again, then abort a window at t1
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h5A5A,16'h0000,16'hBEEF,1,0)); // 31
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h5A5A,16'h0000,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'h0010,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,1,0)); // 35
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        // long window: address change while in DONE is ignored
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h5A5A,16'h1234,16'hBEEF,1,0)); // 38
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0));
        // reset asserted in WAIT1
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,1,0)); // 44
        vecs.push_back(mk(0,1,0,16'h0020,16'h0000,16'h5A5A,16'h1234,16'hBEEF,0,0)); // 45
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h0000,16'h0000,0,0)); // 47
        // abort in WAIT2: data visible combinationally but not held
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h5A5A,16'h0000,16'h0000,1,0)); // 48
        vecs.push_back(mk(1,1,0,16'h0020,16'h0000,16'h5A5A,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h00A5,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0000,16'h5A5A,16'h0000,16'h0000,0,0)); // 51

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
`ifdef MEM_ACCESS_CNT_EN
            if (i == 14) begin
                chk("rd_cnt_o", i, rd_cnt_o, 16'd2);
                chk("wr_cnt_o", i, wr_cnt_o, 16'd1);
            end
            if (i == 45) begin
                chk("rd_cnt_o", i, rd_cnt_o, 16'd8);
                chk("wr_cnt_o", i, wr_cnt_o, 16'd3);
            end
            if (i == 47) begin
                chk("rd_cnt_o", i, rd_cnt_o, 16'd0);
                chk("wr_cnt_o", i, wr_cnt_o, 16'd0);
            end
`endif
        end

        // Switch synchronizer: a change at t0 is not seen by that window, but is by the next
        apply(mk(1,1,0,16'hFFFF,16'h0000,16'h1357,16'h0000,16'h0000,0,0), 100);
        apply(mk(1,1,0,16'hFFFF,16'h0000,16'h1357,16'h0000,16'h0000,0,0), 101);
        apply(mk(1,1,0,16'hFFFF,16'h0000,16'h1357,16'h5A5A,16'h0000,0,0), 102);
        apply(mk(1,0,0,16'hFFFF,16'h0000,16'h1357,16'h5A5A,16'h0000,0,0), 103);
        apply(mk(1,1,0,16'hFFFF,16'h0000,16'h1357,16'h5A5A,16'h0000,0,0), 104);
        apply(mk(1,1,0,16'hFFFF,16'h0000,16'h1357,16'h5A5A,16'h0000,0,0), 105);
        apply(mk(1,1,0,16'hFFFF,16'h0000,16'h1357,16'h1357,16'h0000,0,0), 106);
        apply(mk(1,0,0,16'hFFFF,16'h0000,16'h1357,16'h1357,16'h0000,0,0), 107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
